// File: rtl/key_event_decoder_if.sv
// Key event bus: debounced key edges in, command strobes and held level out.
interface key_event_decoder_if;
  logic key_flag;
  logic key_state;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output key_flag, key_state,
    input  short_pulse, double_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    input  key_flag, key_state,
    output short_pulse, double_pulse, long_pulse, repeat_pulse, held
  );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key presses into short / double / long events and
// emits auto-repeat strobes while a long press is held.
module key_event_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DBL_CYCLES    = 15_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 26
) (
  input logic clk,
  input logic reset,
  key_event_decoder_if.slave kev
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DBL_LAST    = CNT_W'(DBL_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic short_q, short_d;
  logic double_q, double_d;
  logic long_q, long_d;
  logic repeat_q, repeat_d;
  logic held_q, held_d;

  logic press_ev;
  logic rel_ev;

  assign press_ev = kev.key_flag & ~kev.key_state;
  assign rel_ev   = kev.key_flag &  kev.key_state;

  // Key events are tested before counter terminals so they win a tie.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_ONE;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (press_ev) state_d = PRESS1;
      end
      PRESS1: begin
        if (rel_ev) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG;
        end
      end
      WAIT2: begin
        if (press_ev) begin
          state_d = PRESS2;
        end else if (cnt_q == DBL_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (rel_ev) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG;
        end
      end
      LONG: begin
        if (rel_ev) begin
          state_d = IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    held_d = (state_d == PRESS1) || (state_d == PRESS2) || (state_d == LONG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      held_q   <= held_d;
    end
  end

  assign kev.short_pulse  = short_q;
  assign kev.double_pulse = double_q;
  assign kev.long_pulse   = long_q;
  assign kev.repeat_pulse = repeat_q;
  assign kev.held         = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: hand vector table, directed
// corner sequences and random key traffic against an elapsed-time model.
module tb_key_event_decoder;

  localparam int LONG_C = 20;
  localparam int DBL_C  = 10;
  localparam int REP_C  = 5;

  logic clk;
  logic reset;

  key_event_decoder_if kif();

  key_event_decoder #(
    .LONG_CYCLES  (LONG_C),
    .DBL_CYCLES   (DBL_C),
    .REPEAT_CYCLES(REP_C),
    .CNT_W        (26)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kev  (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order everywhere: {held, short, double, long, repeat}.
  typedef enum {KEY_UP, FIRST_DOWN, GAP, SECOND_DOWN, HOLD} phase_t;

  typedef struct {
    bit       flag;
    bit       state;
    int       reps;
    bit [4:0] exp;
  } vec_t;

  phase_t   phase;
  int       now_cycle;
  int       entry_cycle;
  bit [4:0] model_out;

  int n_checks;
  int n_errors;
  int n_short, n_double, n_long, n_repeat;
  int last_short_cycle;

  function automatic bit [4:0] dut_out();
    return {kif.held, kif.short_pulse, kif.double_pulse, kif.long_pulse, kif.repeat_pulse};
  endfunction

  task automatic enter(input phase_t p);
    phase       = p;
    entry_cycle = now_cycle;
  endtask

  task automatic model_reset();
    phase       = KEY_UP;
    entry_cycle = now_cycle;
    model_out   = '0;
  endtask

  // Reference: time spent in the current phase is the edge count since entry.
  task automatic model_step(input bit f, input bit s);
    bit press, rel, sp, dp, lp, rp;
    int el;
    now_cycle++;
    press = f & ~s;
    rel   = f & s;
    el    = now_cycle - entry_cycle;
    {sp, dp, lp, rp} = '0;
    case (phase)
      KEY_UP:      if (press) enter(FIRST_DOWN);
      FIRST_DOWN:  if (rel) enter(GAP);
                   else if (el == LONG_C) begin lp = 1; enter(HOLD); end
      GAP:         if (press) enter(SECOND_DOWN);
                   else if (el == DBL_C) begin sp = 1; enter(KEY_UP); end
      SECOND_DOWN: if (rel) begin dp = 1; enter(KEY_UP); end
                   else if (el == LONG_C) begin lp = 1; enter(HOLD); end
      HOLD:        if (rel) enter(KEY_UP);
                   else if (el > 0 && el % REP_C == 0) rp = 1;
      default:     enter(KEY_UP);
    endcase
    model_out = {(phase == FIRST_DOWN || phase == SECOND_DOWN || phase == HOLD), sp, dp, lp, rp};
  endtask

  task automatic checkOutput(input string name, input bit [4:0] exp);
    bit [4:0] got;
    got = dut_out();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got {held,short,dbl,long,rep}=%b expected=%b at cycle %0d",
               name, got, exp, now_cycle);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic applyStimulus(input bit f, input bit s);
    @(negedge clk);
    kif.key_flag  = f;
    kif.key_state = s;
    @(posedge clk);
    model_step(f, s);
    #1;
    if (kif.short_pulse) begin
      n_short++;
      last_short_cycle = now_cycle;
    end
    if (kif.double_pulse) n_double++;
    if (kif.long_pulse)   n_long++;
    if (kif.repeat_pulse) n_repeat++;
  endtask

  task automatic step_model_check(input string name, input bit f, input bit s);
    applyStimulus(f, s);
    checkOutput(name, model_out);
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) step_model_check(name, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    n_short = 0; n_double = 0; n_long = 0; n_repeat = 0;
    last_short_cycle = -1;
  endtask

  vec_t vecs[$];

  initial begin
    int rel_cycle;
    int rate;

    n_checks  = 0;
    n_errors  = 0;
    now_cycle = 0;
    clear_counts();
    model_reset();

    reset         = 1'b1;
    kif.key_flag  = 1'b0;
    kif.key_state = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 5'b00000);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Hand-derived vectors: stray release, duplicate press, double-click.
    vecs.push_back('{1, 1, 1,  5'b00000});
    vecs.push_back('{0, 0, 2,  5'b00000});
    vecs.push_back('{1, 0, 1,  5'b10000});
    vecs.push_back('{1, 0, 1,  5'b10000});
    vecs.push_back('{0, 0, 2,  5'b10000});
    vecs.push_back('{1, 1, 1,  5'b00000});
    vecs.push_back('{1, 1, 1,  5'b00000});
    vecs.push_back('{0, 0, 2,  5'b00000});
    vecs.push_back('{1, 0, 1,  5'b10000});
    vecs.push_back('{0, 0, 3,  5'b10000});
    vecs.push_back('{1, 1, 1,  5'b00100});
    vecs.push_back('{0, 0, 12, 5'b00000});

    for (int v = 0; v < vecs.size(); v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        applyStimulus(vecs[v].flag, vecs[v].state);
        checkOutput($sformatf("vec%0d", v), vecs[v].exp);
      end
    end

    $display("[TB] short press");
    clear_counts();
    step_model_check("short_press", 1, 0);
    idle_cycles("short_hold", 4);
    step_model_check("short_release", 1, 1);
    rel_cycle = now_cycle;
    idle_cycles("short_wait", 15);
    checkCount("short_count", n_short, 1);
    checkCount("short_latency", last_short_cycle - rel_cycle, DBL_C);
    checkCount("short_others", n_double + n_long + n_repeat, 0);

    $display("[TB] long press with repeat");
    clear_counts();
    step_model_check("long_press", 1, 0);
    idle_cycles("long_hold", 40);
    checkCount("long_count", n_long, 1);
    checkCount("repeat_count", n_repeat, 4);
    step_model_check("long_release", 1, 1);
    checkOutput("long_released_idle", 5'b00000);
    idle_cycles("long_after", 10);
    checkCount("long_after_strobes", n_short + n_double + n_long + n_repeat - 5, 0);

    $display("[TB] release on long terminal");
    clear_counts();
    step_model_check("bnd1_press", 1, 0);
    idle_cycles("bnd1_hold", LONG_C - 1);
    step_model_check("bnd1_release", 1, 1);
    idle_cycles("bnd1_wait", 12);
    checkCount("bnd1_no_long", n_long, 0);
    checkCount("bnd1_short", n_short, 1);

    $display("[TB] press on double-click terminal");
    clear_counts();
    step_model_check("bnd2_press", 1, 0);
    idle_cycles("bnd2_hold", 2);
    step_model_check("bnd2_release", 1, 1);
    idle_cycles("bnd2_gap", DBL_C - 1);
    step_model_check("bnd2_press2", 1, 0);
    idle_cycles("bnd2_hold2", 2);
    step_model_check("bnd2_release2", 1, 1);
    idle_cycles("bnd2_tail", 12);
    checkCount("bnd2_no_short", n_short, 0);
    checkCount("bnd2_double", n_double, 1);

    $display("[TB] reset during long hold");
    step_model_check("rst_press", 1, 0);
    idle_cycles("rst_hold", 25);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_immediate", 5'b00000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    clear_counts();
    idle_cycles("rst_after", 10);
    checkCount("rst_no_pulses", n_short + n_double + n_long + n_repeat, 0);

    $display("[TB] random traffic");
    for (int blk = 0; blk < 15; blk++) begin
      case ($urandom_range(0, 2))
        0:       rate = 3;
        1:       rate = 12;
        default: rate = 40;
      endcase
      for (int i = 0; i < 200; i++) begin
        bit f, s;
        f = ($urandom_range(0, rate) == 0);
        s = 1'($urandom_range(0, 1));
        step_model_check("random", f, s);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety bound in case the stimulus ever stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits directly downstream of the key debouncer (50 MHz domain).
- Consumes the debouncer's one-cycle key_flag pulse and key_state level (0 = pressed, 1 = released).
- Classifies each press into short-press, double-click or long-press events, and emits auto-repeat pulses while the key stays held.
- Outputs drive the robot-arm jog/mode control as single-cycle command strobes.

Parameters:
- LONG_CYCLES, 50_000_000: press duration in clk cycles (1 s) that qualifies as a long press.
- DBL_CYCLES, 15_000_000: maximum gap in clk cycles (300 ms) from a release to the next press for a double-click.
- REPEAT_CYCLES, 10_000_000: auto-repeat period in clk cycles (200 ms) while long-held.
- CNT_W, 26: width of the shared interval counter; must satisfy 2^CNT_W > max(LONG_CYCLES, DBL_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- key_flag  input  1  one-cycle pulse: debounced key edge valid.
- key_state  input  1  debounced level, sampled when key_flag=1 (0 = press edge, 1 = release edge).
- short_pulse  output  1  one-cycle strobe: single short press confirmed.
- double_pulse  output  1  one-cycle strobe: double-click confirmed.
- long_pulse  output  1  one-cycle strobe: long-press threshold reached.
- repeat_pulse  output  1  one-cycle strobe: auto-repeat tick during long hold.
- held  output  1  level: key currently pressed (as seen by the FSM).

Behaviour:
- Reset: clk and reset exactly as decided (reset asynchronous, active-high; clock clk). On reset, state=IDLE, counter=0, all outputs 0. Reset mid-press discards the in-progress event; no pulse is generated on reset release.
- Event decode: press_ev = key_flag & ~key_state; rel_ev = key_flag & key_state.
- Counter: counts only in PRESS1, WAIT2, PRESS2 and LONG. It clears to 0 on every state entry, and in LONG also when a repeat fires. Terminal value is (X_CYCLES - 1) for the relevant parameter.
- IDLE:
  - press_ev -> PRESS1.
  - rel_ev is ignored.
- PRESS1:
  - rel_ev -> WAIT2.
  - Else counter == LONG_CYCLES-1 -> long_pulse, -> LONG.
- WAIT2:
  - press_ev -> PRESS2.
  - Else counter == DBL_CYCLES-1 -> short_pulse, -> IDLE.
- PRESS2:
  - rel_ev -> double_pulse, -> IDLE.
  - Else counter == LONG_CYCLES-1 -> long_pulse, -> LONG; the double-click is discarded.
- LONG:
  - rel_ev -> IDLE, no pulse.
  - Else counter == REPEAT_CYCLES-1 -> repeat_pulse, counter clears.
- Simultaneous events: a key event and a counter terminal in the same cycle resolve in favour of the key event; no timeout pulse is emitted.
- Redundant events (press_ev in PRESS1/PRESS2/LONG, rel_ev in WAIT2) are ignored; state and counter are unchanged.
- held = 1 in PRESS1, PRESS2 and LONG; 0 otherwise.
- Latency: all outputs are registered. A strobe is high for exactly one cycle, in the cycle after the deciding key_flag or counter terminal. At most one strobe is high in any cycle.
- Short press is reported DBL_CYCLES after release. This is the accepted cost of double-click detection.
- default/illegal state -> IDLE, counter cleared, outputs 0.

Test Plan (bench overrides LONG_CYCLES=20, DBL_CYCLES=10, REPEAT_CYCLES=5):
1. Short press: press_ev at t0, rel_ev at t0+5 -> held high t0+1..t0+5; short_pulse exactly once, 10 cycles after the release is registered; no other strobes.
2. Double-click: press t0, release t0+4, press t0+8, release t0+12 -> single double_pulse in the cycle after the second release; no short_pulse.
3. Long + repeat: press t0, held 40 cycles -> long_pulse once ~20 cycles after entry; repeat_pulse every 5 cycles afterwards (4 pulses); release -> IDLE, no further strobes, held=0.
4. Boundary: rel_ev coincident with PRESS1 counter==19 -> no long_pulse; FSM goes to WAIT2 and later short_pulse. Press arriving on WAIT2 counter==9 -> PRESS2, no short_pulse.
5. Robustness: stray rel_ev in IDLE and duplicate press_ev in PRESS1 -> no state change, no strobes. Reset asserted mid-LONG -> all outputs 0 immediately; after deassertion, idle with no pulses until a new press.
